// File: rtl/sphere_frame_unpacker_pkg.sv
// Shared types for the MCU-to-FPGA scene link: the packed Sphere record
// and the unpacker FSM state encoding.
package sphere_frame_unpacker_pkg;

    typedef struct packed {
        logic [15:0] x;
        logic [13:0] y;
        logic [15:0] z;
        logic [5:0]  r;
        logic [11:0] c;
    } Sphere;

    localparam int SPHERE_BYTES = 8;
    localparam int SPHERE_W     = $bits(Sphere);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        PAYLOAD
    } UnpackState;

endpackage

// File: rtl/sphere_out_slot.sv
// Single-entry valid/ready holding register for assembled sphere records.
// A new record is taken when the slot is empty or being accepted this
// cycle; otherwise it is dropped and flagged as an overrun.
module sphere_out_slot
    import sphere_frame_unpacker_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [SPHERE_W-1:0] load_data,
    input  logic [IDX_W-1:0]    load_index,
    input  logic                load_last,
    input  logic                ready,
    output logic                valid,
    output logic [SPHERE_W-1:0] data,
    output logic [IDX_W-1:0]    index,
    output logic                last,
    output logic                overrun
);

    // A record arriving while the slot is full and not draining is lost.
    assign overrun = load & valid & ~ready;

    // Hold until handshake; reload in the same cycle as an accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            index <= '0;
            last  <= 1'b0;
        end else if (load && (!valid || ready)) begin
            valid <= 1'b1;
            data  <= load_data;
            index <= load_index;
            last  <= load_last;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sphere_frame_unpacker.sv
// Receiver end of the scene link: parses a count byte followed by N
// eight-byte Sphere records (MSB first) and presents them one at a time.
module sphere_frame_unpacker
    import sphere_frame_unpacker_pkg::*;
#(
    parameter int MAX_SPHERES = 16,
    parameter int IDX_W       = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_start,
    input  logic                byte_valid,
    input  logic [7:0]          byte_data,
    output logic                sphere_valid,
    input  logic                sphere_ready,
    output logic [SPHERE_W-1:0] sphere_out,
    output logic [IDX_W-1:0]    sphere_index,
    output logic                sphere_last,
    output logic                frame_done,
    output logic                err_overrun,
    output logic                err_frame
);

    // One extra bit so a count equal to 2**IDX_W still fits.
    localparam int         CNT_W     = IDX_W + 1;
    localparam logic [7:0] MAX_B     = 8'(MAX_SPHERES);
    localparam logic [2:0] LAST_BYTE = 3'(SPHERE_BYTES - 1);

    UnpackState          state;
    logic [CNT_W-1:0]    n;
    logic [CNT_W-1:0]    sph_cnt;
    logic [2:0]          byte_cnt;
    // Only the first seven bytes of a record are ever stored; the eighth
    // is taken straight from byte_data when the record completes.
    logic [SPHERE_W-9:0] acc;
    logic                zero_done;
    logic                done_pend;

    logic                take;
    logic                accept;
    logic                slot_overrun;
    logic                rec_vld_p0;
    logic                rec_last_p0;
    logic [SPHERE_W-1:0] rec_data_p0;

    // frame_start always wins over a byte in the same cycle.
    assign take        = byte_valid & ~frame_start;
    assign rec_vld_p0  = (state == PAYLOAD) & take & (byte_cnt == LAST_BYTE);
    assign rec_data_p0 = {acc, byte_data};
    assign rec_last_p0 = (sph_cnt == n - CNT_W'(1));
    assign accept      = sphere_valid & sphere_ready;
    // done_pend marks that the frame's final record has been seen (kept or
    // dropped); whatever the slot holds then is the last deliverable one.
    assign frame_done  = (accept & done_pend) | zero_done;

    // Frame FSM, counters and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            n           <= '0;
            sph_cnt     <= '0;
            byte_cnt    <= '0;
            zero_done   <= 1'b0;
            done_pend   <= 1'b0;
            err_frame   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            zero_done <= 1'b0;
            if (slot_overrun) begin
                err_overrun <= 1'b1;
            end
            if (accept && done_pend) begin
                done_pend <= 1'b0;
            end
            if (rec_vld_p0 && rec_last_p0) begin
                done_pend <= 1'b1;
            end
            if (frame_start) begin
                if (state != IDLE) begin
                    err_frame <= 1'b1;
                end
                err_overrun <= 1'b0;
                byte_cnt    <= '0;
                state       <= COUNT;
            end else if (byte_valid) begin
                unique case (state)
                    COUNT: begin
                        if (byte_data == 8'd0) begin
                            zero_done <= 1'b1;
                            state     <= IDLE;
                        end else if (byte_data > MAX_B) begin
                            err_frame <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            n        <= byte_data[CNT_W-1:0];
                            byte_cnt <= '0;
                            sph_cnt  <= '0;
                            state    <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        byte_cnt <= byte_cnt + 3'd1;
                        if (byte_cnt == LAST_BYTE) begin
                            sph_cnt <= sph_cnt + CNT_W'(1);
                            if (rec_last_p0) begin
                                state <= IDLE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Byte accumulator: shift each payload byte in MSB first.
    always_ff @(posedge clk) begin
        if (state == PAYLOAD && take) begin
            acc <= {acc[SPHERE_W-17:0], byte_data};
        end
    end

    sphere_out_slot #(
        .IDX_W(IDX_W)
    ) u_slot (
        .clk        (clk),
        .rst        (rst),
        .load       (rec_vld_p0),
        .load_data  (rec_data_p0),
        .load_index (sph_cnt[IDX_W-1:0]),
        .load_last  (rec_last_p0),
        .ready      (sphere_ready),
        .valid      (sphere_valid),
        .data       (sphere_out),
        .index      (sphere_index),
        .last       (sphere_last),
        .overrun    (slot_overrun)
    );

endmodule

// File: tb/tb_sphere_frame_unpacker.sv
// Self-checking bench for sphere_frame_unpacker: directed and randomized
// frames compared against a frame-level reference model.
module tb_sphere_frame_unpacker;

    localparam int MAX_SPHERES = 16;
    localparam int IDX_W       = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        sphere_valid;
    logic        sphere_ready;
    logic [63:0] sphere_out;
    logic [IDX_W-1:0] sphere_index;
    logic        sphere_last;
    logic        frame_done;
    logic        err_overrun;
    logic        err_frame;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int exp_done = 0;

    logic [63:0] got_d[$];
    logic [63:0] exp_d[$];
    int          got_i[$];
    int          exp_i[$];
    logic        got_l[$];
    logic        exp_l[$];
    logic [7:0]  fb[$];

    always #5 clk = ~clk;

    sphere_frame_unpacker #(
        .MAX_SPHERES(MAX_SPHERES),
        .IDX_W(IDX_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .sphere_valid (sphere_valid),
        .sphere_ready (sphere_ready),
        .sphere_out   (sphere_out),
        .sphere_index (sphere_index),
        .sphere_last  (sphere_last),
        .frame_done   (frame_done),
        .err_overrun  (err_overrun),
        .err_frame    (err_frame)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // One clock: observe handshakes at the falling edge, return just after the rising edge.
    task automatic step();
        @(negedge clk);
        if (sphere_valid && sphere_ready) begin
            got_d.push_back(sphere_out);
            got_i.push_back(int'(sphere_index));
            got_l.push_back(sphere_last);
        end
        if (frame_done) done_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        byte_valid  = 1'b0;
        frame_start = 1'b0;
        repeat (k) step();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat ($urandom_range(0, gap)) idle(1);
        byte_valid = 1'b1;
        byte_data  = b;
        step();
        byte_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cnt, input int gap);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        send_byte(cnt, gap);
        foreach (fb[k]) send_byte(fb[k], gap);
    endtask

    task automatic fill_random(input int nbytes);
        fb.delete();
        repeat (nbytes) fb.push_back(8'($urandom_range(0, 255)));
    endtask

    function automatic logic [63:0] rec_at(input int i);
        logic [63:0] r = '0;
        for (int j = 0; j < 8; j++) r = {r[55:0], fb[8*i+j]};
        return r;
    endfunction

    // Expected records for a frame of count cnt carrying the bytes in fb,
    // assuming the consumer is always ready.
    function automatic void model_frame(input int cnt);
        int full = fb.size() / 8;
        int nrec = 0;
        if (cnt > 0 && cnt <= MAX_SPHERES) nrec = (cnt < full) ? cnt : full;
        for (int i = 0; i < nrec; i++) begin
            exp_d.push_back(rec_at(i));
            exp_i.push_back(i);
            exp_l.push_back(i == cnt - 1);
        end
        if (cnt == 0 || (cnt <= MAX_SPHERES && full >= cnt)) exp_done++;
    endfunction

    task automatic compare_all(input string tag);
        int m = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
        chk({tag, "_nrec"}, 64'(got_d.size()), 64'(exp_d.size()));
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
            chk($sformatf("%s_idx%0d", tag, i), 64'(got_i[i]), 64'(exp_i[i]));
            chk($sformatf("%s_last%0d", tag, i), 64'(got_l[i]), 64'(exp_l[i]));
        end
        chk({tag, "_done"}, 64'(done_cnt), 64'(exp_done));
        got_d.delete(); got_i.delete(); got_l.delete();
        exp_d.delete(); exp_i.delete(); exp_l.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(sphere_valid), 64'd0);
        chk({tag, "_out"},   sphere_out, 64'd0);
        chk({tag, "_index"}, 64'(sphere_index), 64'd0);
        chk({tag, "_last"},  64'(sphere_last), 64'd0);
        chk({tag, "_done"},  64'(frame_done), 64'd0);
        chk({tag, "_eovr"},  64'(err_overrun), 64'd0);
        chk({tag, "_efrm"},  64'(err_frame), 64'd0);
    endtask

    initial begin
        logic [63:0] rec0;
        logic [63:0] s;
        int cnt;

        rst = 1'b1; frame_start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        sphere_ready = 1'b1;
        repeat (3) step();
        chk_reset_outputs("reset");
        rst = 1'b0;
        idle(1);

        // Known single-sphere frame
        fb.delete();
        fb.push_back(8'h00); fb.push_back(8'h10); fb.push_back(8'h00); fb.push_back(8'h20);
        fb.push_back(8'h00); fb.push_back(8'h30); fb.push_back(8'h14); fb.push_back(8'hFF);
        send_frame(8'd1, 0);
        idle(3);
        s = (got_d.size() > 0) ? got_d[0] : 64'd0;
        chk("t1_raw", s, 64'h0010_0020_0030_14FF);
        chk("t1_x", (s >> 48) & 64'hFFFF, 64'h0010);
        chk("t1_y", (s >> 34) & 64'h3FFF, 64'h0008);
        chk("t1_z", (s >> 18) & 64'hFFFF, 64'h000C);
        chk("t1_r", (s >> 12) & 64'h3F,   64'h1);
        chk("t1_c", s & 64'hFFF,          64'h4FF);
        model_frame(1);
        compare_all("t1");

        // Three spheres, bytes back-to-back
        fill_random(24);
        send_frame(8'd3, 0);
        idle(3);
        model_frame(3);
        compare_all("t2");
        chk("t2_eovr", 64'(err_overrun), 64'd0);
        chk("t2_efrm", 64'(err_frame), 64'd0);

        // Random frames, including the largest legal count
        for (int f = 0; f < 6; f++) begin
            cnt = (f == 0) ? MAX_SPHERES : int'($urandom_range(1, MAX_SPHERES));
            fill_random(cnt * 8);
            send_frame(8'(cnt), f % 3);
            idle(3);
            model_frame(cnt);
            compare_all($sformatf("rnd%0d", f));
        end
        chk("rnd_eovr", 64'(err_overrun), 64'd0);

        // Overrun: consumer stalled across both records of a 2-sphere frame
        sphere_ready = 1'b0;
        fill_random(16);
        rec0 = rec_at(0);
        send_frame(8'd2, 0);
        idle(2);
        chk("ovr_valid", 64'(sphere_valid), 64'd1);
        chk("ovr_out",   sphere_out, rec0);
        chk("ovr_index", 64'(sphere_index), 64'd0);
        chk("ovr_last",  64'(sphere_last), 64'd0);
        chk("ovr_flag",  64'(err_overrun), 64'd1);
        chk("ovr_nodone", 64'(done_cnt), 64'(exp_done));
        sphere_ready = 1'b1;
        step();
        exp_d.push_back(rec0); exp_i.push_back(0); exp_l.push_back(1'b0);
        exp_done++;
        compare_all("ovr");
        step();
        chk("ovr_drop", 64'(sphere_valid), 64'd0);
        fb.delete();
        send_frame(8'd0, 0);
        idle(2);
        model_frame(0);
        chk("ovr_clear", 64'(err_overrun), 64'd0);
        compare_all("zero");

        // Count above the limit, then a good frame
        fill_random(8);
        send_frame(8'h11, 0);
        idle(2);
        chk("big_efrm", 64'(err_frame), 64'd1);
        chk("big_valid", 64'(sphere_valid), 64'd0);
        model_frame(17);
        compare_all("big");
        fill_random(8);
        send_frame(8'd1, 1);
        idle(3);
        model_frame(1);
        compare_all("after_big");

        // frame_start arriving after byte 5 of the second sphere
        rst = 1'b1; step(); rst = 1'b0; idle(1);
        chk("mid_efrm0", 64'(err_frame), 64'd0);
        fill_random(13);
        send_frame(8'd2, 0);
        model_frame(2);
        fill_random(8);
        send_frame(8'd1, 0);
        idle(3);
        model_frame(1);
        compare_all("mid");
        chk("mid_efrm1", 64'(err_frame), 64'd1);

        // Reset in the middle of a payload with a sphere pending
        sphere_ready = 1'b0;
        fill_random(11);
        send_frame(8'd3, 0);
        chk("rstmid_pend", 64'(sphere_valid), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_outputs("rstmid");
        sphere_ready = 1'b1;
        fb.delete();
        send_frame(8'd0, 0);
        idle(3);
        model_frame(0);
        compare_all("rstmid_zero");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
